// File: rtl/headlight_pkg.sv
// Shared types and constants for the tail-light front end (arbiter FSM states,
// lamp pattern codes, sequencer step encodings).
`timescale 1ns/1ps
package headlight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEFT   = 3'd1,
    ST_RIGHT  = 3'd2,
    ST_HAZARD = 3'd3,
    ST_CLEAR  = 3'd4
  } arb_state_t;

  localparam logic [2:0] LAMP_OFF  = 3'b000;
  localparam logic [2:0] LAMP_FULL = 3'b111;

  localparam logic [2:0] SEQ_S0 = 3'd0;
  localparam logic [2:0] SEQ_S1 = 3'd1;
  localparam logic [2:0] SEQ_S2 = 3'd2;
  localparam logic [2:0] SEQ_S3 = 3'd3;
  localparam logic [2:0] SEQ_S4 = 3'd4;
  localparam logic [2:0] SEQ_S5 = 3'd5;

  function automatic logic lamps_full(input logic [2:0] p);
    return (p == LAMP_FULL);
  endfunction

  function automatic logic lamps_off(input logic [2:0] p);
    return (p == LAMP_OFF);
  endfunction

  // Command bundle {lt, rt, haz, busy} driven while resident in a state
  function automatic logic [3:0] cmd_of(input arb_state_t s);
    case (s)
      ST_IDLE:   return 4'b0000;
      ST_LEFT:   return 4'b1001;
      ST_RIGHT:  return 4'b0101;
      ST_HAZARD: return 4'b0011;
      ST_CLEAR:  return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a debounce counter: the clean level flips
// only after DEB_CYCLES consecutive synced samples that differ from it.
`timescale 1ns/1ps
module input_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_clean
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_clean;

  // Synchronise, then count the run of samples disagreeing with the clean level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] != r_clean) begin
        if (r_cnt == CNT_LAST) begin
          r_clean <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/turn_signal_arbiter.sv
// Turn/hazard arbiter: debounced levers, IDLE/LEFT/RIGHT/HAZARD/CLEAR FSM,
// step-tick prescaler and lane-change sweep counter, all outputs registered.
`timescale 1ns/1ps
module turn_signal_arbiter
  import headlight_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int DEB_CYCLES  = 3,
  parameter int LANE_BLINKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic       rt_req,
  input  logic       haz_req,
  input  logic       lane_mode,
  input  logic       cancel,
  input  logic [2:0] li,
  input  logic [2:0] ri,
  output logic       lt,
  output logic       rt,
  output logic       haz,
  output logic       tick,
  output logic       busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (LANE_BLINKS > 1) ? $clog2(LANE_BLINKS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SW_LAST  = SW'(LANE_BLINKS - 1);

  logic w_lt_c, w_rt_c, w_hz_c;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lt (.clk(clk), .rst(rst), .i_raw(lt_req),  .o_clean(w_lt_c));
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rt (.clk(clk), .rst(rst), .i_raw(rt_req),  .o_clean(w_rt_c));
  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hz (.clk(clk), .rst(rst), .i_raw(haz_req), .o_clean(w_hz_c));

  arb_state_t    r_state;
  logic [3:0]    r_cmd;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_sw;
  logic          r_lane;
  logic          r_tick;

  logic       w_in_turn, w_mine, w_other, w_sweep, w_lane_done;
  logic       w_idle_go, w_idle_haz, w_entry, w_next_idle;
  logic       w_turn_exit, w_haz_exit, w_to_idle;
  logic [2:0] w_own;

  assign w_in_turn   = (r_state == ST_LEFT) || (r_state == ST_RIGHT);
  assign w_mine      = (r_state == ST_LEFT) ? w_lt_c : w_rt_c;
  assign w_other     = (r_state == ST_LEFT) ? w_rt_c : w_lt_c;
  assign w_own       = (r_state == ST_RIGHT) ? ri : li;
  assign w_sweep     = r_tick && lamps_full(w_own);
  assign w_lane_done = w_sweep && (r_sw == SW_LAST);

  assign w_idle_haz  = w_hz_c || (w_lt_c && w_rt_c);
  assign w_idle_go   = w_hz_c || w_lt_c || w_rt_c;
  assign w_entry     = (r_state == ST_IDLE) && w_idle_go;
  assign w_to_idle   = (r_state == ST_CLEAR) && lamps_off(li) && lamps_off(ri);
  assign w_next_idle = ((r_state == ST_IDLE) && !w_idle_go) || w_to_idle;

  // A latched lane-change turn ignores release and ends on its sweep budget
  assign w_turn_exit = cancel || w_hz_c || w_other || (r_lane ? w_lane_done : !w_mine);
  assign w_haz_exit  = cancel || (!w_hz_c && !(w_lt_c && w_rt_c));

  // Arbitration FSM with Moore-registered command bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= 4'b0000;
      r_lane  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_idle_haz) begin
            r_state <= ST_HAZARD;
            r_cmd   <= cmd_of(ST_HAZARD);
          end else if (w_lt_c) begin
            r_state <= ST_LEFT;
            r_cmd   <= cmd_of(ST_LEFT);
            r_lane  <= lane_mode;
          end else if (w_rt_c) begin
            r_state <= ST_RIGHT;
            r_cmd   <= cmd_of(ST_RIGHT);
            r_lane  <= lane_mode;
          end else begin
            r_cmd   <= cmd_of(ST_IDLE);
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (w_turn_exit) begin
            r_state <= ST_CLEAR;
            r_cmd   <= cmd_of(ST_CLEAR);
          end else begin
            r_cmd   <= cmd_of(r_state);
          end
        end
        ST_HAZARD: begin
          if (w_haz_exit) begin
            r_state <= ST_CLEAR;
            r_cmd   <= cmd_of(ST_CLEAR);
          end else begin
            r_cmd   <= cmd_of(ST_HAZARD);
          end
        end
        ST_CLEAR: begin
          if (w_to_idle) begin
            r_state <= ST_IDLE;
            r_cmd   <= cmd_of(ST_IDLE);
          end else begin
            r_cmd   <= cmd_of(ST_CLEAR);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cmd   <= 4'b0000;
          r_lane  <= 1'b0;
        end
      endcase
    end
  end

  // Step prescaler: restarts with each new command, parked at zero while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pre == PRE_LAST) && !w_entry && !w_next_idle;
      if (w_entry || w_next_idle) begin
        r_pre <= '0;
      end else if (r_pre == PRE_LAST) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // Completed own-side sweeps since the turn began
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw <= '0;
    end else if (w_entry) begin
      r_sw <= '0;
    end else if (w_in_turn && w_sweep && (r_sw != SW_LAST)) begin
      r_sw <= r_sw + SW'(1);
    end else begin
      r_sw <= r_sw;
    end
  end

  assign lt   = r_cmd[3];
  assign rt   = r_cmd[2];
  assign haz  = r_cmd[1];
  assign busy = r_cmd[0];
  assign tick = r_tick;

endmodule
